test_run_monitor: RTL and testbench
===================================

Name: test_run_monitor

Overview:
Harness stage wrapped around one or more self-checking test blocks. Upstream, it drives their `test_reset` for a fixed number of cycles after harness reset. Downstream, it consumes each test's `fail`/`finish` pair, applies a timeout watchdog, and reduces everything to a latched `done`/`pass` verdict with a per-test fail mask and a run-cycle count. It is the top of each CI simulation; the simulator exits on `done`.

Parameters:
- NUM_TESTS, 1: number of test blocks monitored; 1..32.
- RESET_CYCLES, 4: cycles `test_reset` is held high after harness reset; >=1.
- TIMEOUT_CYCLES, 1000: RUN cycles allowed before the timeout verdict; >=1.
- CNT_W, 32: width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  harness clock
- reset  input  1  synchronous, active-high harness reset
- test_reset  output  1  reset driven to all test blocks
- test_fail  input  NUM_TESTS  per-test fail flag (bit i = test i)
- test_finish  input  NUM_TESTS  per-test finish flag
- done  output  1  verdict valid, held until reset
- pass  output  1  all tests finished with no fail and no timeout; meaningful only when done=1
- timeout  output  1  watchdog expired before all tests finished
- fail_mask  output  NUM_TESTS  sticky per-test fail record
- cycles  output  CNT_W  RUN cycles elapsed

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- State machine: HOLD -> RUN -> DONE.
  - HOLD: load counter=0 on entry; `test_reset`=1. After RESET_CYCLES HOLD cycles, go to RUN, so `test_reset` is high for exactly RESET_CYCLES cycles after reset deasserts.
  - RUN: `test_reset`=0. Each cycle: `fail_mask |= test_fail`; `fin_mask |= test_finish` (internal register); `cycles += 1`.
  - RUN exit: if `(fin_mask | test_finish)` is all ones, go to DONE. Otherwise, if this is RUN cycle index TIMEOUT_CYCLES-1, go to DONE with `timeout`=1.
  - DONE: absorbing. All outputs are frozen; `test_fail`/`test_finish` are ignored; `test_reset` stays 0.
- Reset values: `done`=0, `pass`=0, `timeout`=0, `fail_mask`=0, `cycles`=0. State goes to HOLD.
- `test_reset` = `reset` OR (state==HOLD), so it is asserted combinationally in the same cycle `reset` is high.
- `test_fail`/`test_finish` are ignored while `test_reset`=1 (HOLD or reset); test outputs may be X then.
- Verdict is registered: `done` rises the cycle after the final RUN sample. `pass` = (final `fail_mask`==0) AND NOT `timeout`, written together with `done`.
- `cycles` on DONE = number of RUN cycles, including the cycle that completed or timed out. `cycles` never exceeds TIMEOUT_CYCLES.
- Simultaneous events:
  - `fail` and `finish` in the same cycle: both recorded; the fail counts.
  - Last `finish` arriving in RUN cycle TIMEOUT_CYCLES-1: completion wins, `timeout`=0.
- `finish` may precede `fail` for the same test; a later fail is still recorded until DONE.
- Flags are sticky: a `test_finish`/`test_fail` that drops after rising still counts.
- Reset mid-RUN or in DONE: the next cycle is a fresh HOLD. All outputs and masks clear; the full RESET_CYCLES hold repeats.

Optional Feature:
- Macro TEST_RUN_MONITOR_DISPLAY_EN.
- Defined: on the single cycle of DONE entry, print exactly one of `~~PASS~~`, `~~FAIL~~` or `~~TIMEOUT~~` via `$display`, followed by the `cycles` value and `fail_mask` in hex. Nothing is printed in any other cycle.
- Undefined: no `$display` present; ports and timing identical.

Test Plan:
(NUM_TESTS=2, RESET_CYCLES=4, TIMEOUT_CYCLES=16)
1. Release reset; hold `test_fail`=0. Pulse `test_finish`=2'b01 at RUN cycle 2 and 2'b10 at RUN cycle 5 -> `test_reset` high for exactly 4 cycles; `done`=1, `pass`=1, `cycles`=6, `fail_mask`=0.
2. `test_fail`[1] pulses at RUN cycle 1; both finish at RUN cycle 3 -> `done`=1, `pass`=0, `fail_mask`=2'b10, `timeout`=0, `cycles`=4.
3. Only test 0 finishes -> `done` rises after RUN cycle 15; `timeout`=1, `pass`=0, `cycles`=16.
4. Test 1 finishes in RUN cycle 15 while test 0 finished earlier -> `timeout`=0, `pass`=1, `cycles`=16.
5. `test_fail`=2'b11 and `test_finish`=2'b11 driven during HOLD, then 0 in RUN -> ignored; with finishes later at RUN cycle 1, `pass`=1.
6. Assert `reset` at RUN cycle 3 with `fail_mask`=2'b01 -> `test_reset` high same cycle; masks, `cycles` and `done` clear; a new 4-cycle HOLD follows. Also assert `reset` after DONE -> same clearing.

Source files
------------

// File: rtl/test_run_monitor.sv
// Harness monitor: holds test_reset after harness reset, then folds per-test fail/finish
// flags and a watchdog into a latched verdict. Optional DONE banner: TEST_RUN_MONITOR_DISPLAY_EN.
module test_run_monitor #(
  parameter int NUM_TESTS      = 1,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 test_reset,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     cycles
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [NUM_TESTS-1:0] fin_mask;
  logic [NUM_TESTS-1:0] fail_nxt;
  logic [NUM_TESTS-1:0] fin_nxt;
  logic                 finish_run;
  logic                 timeout_run;

  // Test blocks see reset in the same cycle the harness reset is applied.
  assign test_reset = reset | (state == HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion takes priority over the watchdog on the last allowed RUN cycle.
  always_comb begin
    state_nxt   = state;
    fail_nxt    = fail_mask | test_fail;
    fin_nxt     = fin_mask | test_finish;
    finish_run  = 1'b0;
    timeout_run = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (&fin_nxt) begin
          state_nxt  = DONE;
          finish_run = 1'b1;
        end else if (cycles == RUN_LAST) begin
          state_nxt   = DONE;
          timeout_run = 1'b1;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt  <= '0;
      fin_mask  <= '0;
      fail_mask <= '0;
      cycles    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          fail_mask <= fail_nxt;
          fin_mask  <= fin_nxt;
          cycles    <= cycles + 1'b1;
          if (finish_run || timeout_run) begin
            done    <= 1'b1;
            timeout <= timeout_run;
            pass    <= finish_run && (fail_nxt == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TEST_RUN_MONITOR_DISPLAY_EN
  always_ff @(posedge clock) begin
    if (!reset && (finish_run || timeout_run)) begin
      if (timeout_run) begin
        $display("~~TIMEOUT~~ cycles=%h fail_mask=%h", cycles + 1'b1, fail_nxt);
      end else if (fail_nxt != '0) begin
        $display("~~FAIL~~ cycles=%h fail_mask=%h", cycles + 1'b1, fail_nxt);
      end else begin
        $display("~~PASS~~ cycles=%h fail_mask=%h", cycles + 1'b1, fail_nxt);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_test_run_monitor.sv
// Scoreboard bench for test_run_monitor: driver pushes expected verdicts computed from the
// per-cycle stimulus tables; a negedge monitor pops and compares when done rises.
module tb_test_run_monitor;

  localparam int NT = 2;
  localparam int RC = 4;
  localparam int TO = 16;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          test_reset;
  logic [NT-1:0] test_fail = '0;
  logic [NT-1:0] test_finish = '0;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [NT-1:0] fail_mask;
  logic [CW-1:0] cycles;

  typedef struct {
    int            cyc;
    logic [NT-1:0] mask;
    bit            to;
    bit            ok;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [NT-1:0] stim_fail[TO];
  logic [NT-1:0] stim_fin[TO];
  int            total = 0;
  int            bad = 0;
  bit            was_done = 1'b0;

  always #5 clock = ~clock;

  test_run_monitor #(
    .NUM_TESTS(NT),
    .RESET_CYCLES(RC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .test_reset(test_reset),
    .test_fail(test_fail),
    .test_finish(test_finish),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_mask(fail_mask),
    .cycles(cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the verdict follows from the first cycle at which every test has finished.
  function automatic exp_t model();
    exp_t          e;
    logic [NT-1:0] fm = '0;
    logic [NT-1:0] nm = '0;
    for (int k = 0; k < TO; k++) begin
      fm |= stim_fail[k];
      nm |= stim_fin[k];
      if (nm == {NT{1'b1}}) begin
        e.cyc = k + 1; e.mask = fm; e.to = 1'b0; e.ok = (fm == '0);
        return e;
      end
    end
    e.cyc = TO; e.mask = fm; e.to = 1'b1; e.ok = 1'b0;
    return e;
  endfunction

  task automatic clear_stim();
    for (int k = 0; k < TO; k++) begin
      stim_fail[k] = '0;
      stim_fin[k]  = '0;
    end
  endtask

  task automatic run_scn(input int reset_at, input bit rnd_hold, input logic [NT-1:0] hold_v);
    exp_t          e;
    int            hcnt = 0;
    int            k = 0;
    int            it = 0;
    bit            seen = 1'b0;
    logic [NT-1:0] fm = '0;
    e = model();
    if (reset_at < 0 || reset_at >= e.cyc) exp_q.push_back(e);
    @(posedge clock); #1;
    reset = 1'b1;
    test_fail = NT'($urandom);
    test_finish = NT'($urandom);
    @(posedge clock); #1;
    chk("rst_test_reset", 32'(test_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_fail_mask", 32'(fail_mask), 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b0;
    while (it < 3 * TO && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else if (test_reset) begin
        hcnt++;
        test_fail   = rnd_hold ? NT'($urandom) : hold_v;
        test_finish = rnd_hold ? NT'($urandom) : hold_v;
      end else if (k == reset_at) begin
        chk("midrun_fail_mask", 32'(fail_mask), 32'(fm));
        chk("midrun_cycles", cycles, k);
        chk("hold_len", hcnt, RC);
        reset = 1'b1;
        #1;
        chk("midrun_test_reset", 32'(test_reset), 1);
        return;
      end else begin
        test_fail   = (k < TO) ? stim_fail[k] : '0;
        test_finish = (k < TO) ? stim_fin[k] : '0;
        if (k < TO) fm |= stim_fail[k];
        k++;
      end
      it++;
      if (!seen) begin
        @(posedge clock); #1;
      end
    end
    chk("hold_len", hcnt, RC);
    chk("done_seen", 32'(seen), 1);
    repeat (3) begin
      test_fail = NT'($urandom);
      test_finish = NT'($urandom);
      @(posedge clock); #1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (done && !was_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 0);
        end else begin
          cur = exp_q.pop_front();
          chk("pass", 32'(pass), 32'(cur.ok));
          chk("timeout", 32'(timeout), 32'(cur.to));
          chk("fail_mask", 32'(fail_mask), 32'(cur.mask));
          chk("cycles", cycles, cur.cyc);
          chk("test_reset_done", 32'(test_reset), 0);
        end
      end else if (done) begin
        chk("frozen_pass", 32'(pass), 32'(cur.ok));
        chk("frozen_timeout", 32'(timeout), 32'(cur.to));
        chk("frozen_fail_mask", 32'(fail_mask), 32'(cur.mask));
        chk("frozen_cycles", cycles, cur.cyc);
      end
      was_done = done;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    clear_stim(); stim_fin[2] = 2'b01; stim_fin[5] = 2'b10;
    run_scn(-1, 1'b0, 2'b00);
    clear_stim(); stim_fail[1] = 2'b10; stim_fin[3] = 2'b11;
    run_scn(-1, 1'b0, 2'b00);
    clear_stim(); stim_fin[4] = 2'b01;
    run_scn(-1, 1'b0, 2'b00);
    clear_stim(); stim_fin[3] = 2'b01; stim_fin[15] = 2'b10;
    run_scn(-1, 1'b0, 2'b00);
    clear_stim(); stim_fin[1] = 2'b11;
    run_scn(-1, 1'b0, 2'b11);
    clear_stim(); stim_fail[1] = 2'b01;
    run_scn(3, 1'b0, 2'b00);
    clear_stim(); stim_fail[0] = 2'b11; stim_fin[0] = 2'b11;
    run_scn(-1, 1'b1, 2'b00);
    for (int s = 0; s < 24; s++) begin
      for (int k = 0; k < TO; k++) begin
        stim_fin[k]  = ($urandom_range(0, 5) == 0) ? NT'($urandom) : '0;
        stim_fail[k] = ($urandom_range(0, 9) == 0) ? NT'($urandom) : '0;
      end
      run_scn(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 12)) : -1, 1'b1, 2'b00);
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
